hamming_secded_pipe: RTL

Parametrised, pipelined Hamming SECDED decoder, successor to the combinational (7,4) Hamming decoder.
- Accepts extended codewords of 2^R bits: positions 1..N (N=2^R-1) hold the Hamming code and position 0 holds the overall parity bit.
- Corrects single errors, flags double errors and extracts the data bits.
- Sits between a memory/link receiver and consumers, with valid/ready flow control on both sides.

---
 rtl/hamming_pkg.sv | 45 ++++
 rtl/hamming_syndrome.sv | 22 ++
 rtl/hamming_secded_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared sizing helpers and status encoding for the pipelined Hamming SECDED decoder.
// Optional error counters in the top are enabled by HAMMING_ERR_CNT_EN.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_OK   = 2'd1,
        ST_CORR = 2'd2,
        ST_UNC  = 2'd3
    } status_e;

    function automatic int calc_n(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int calc_k(input int r);
        return calc_n(r) - r;
    endfunction

    // Position of the idx-th non-power-of-two codeword position, ascending.
    function automatic int data_pos(input int r, input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int p = 1; p <= calc_n(r); p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    // Bitmask of codeword positions that contribute to syndrome bit j.
    function automatic logic [63:0] group_mask(input int r, input int j);
        logic [63:0] m;
        m = '0;
        for (int p = 1; p <= calc_n(r); p++) begin
            if (((p >> j) & 1) == 1) m = m | (64'(1) << p);
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and overall-parity computation for an extended
// Hamming codeword with R check bits.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int R = 3
) (
    input  logic [calc_n(R):0] du,
    output logic [R-1:0]       syndrome,
    output logic               parity
);

    localparam int N = calc_n(R);

    for (genvar j = 0; j < R; j++) begin : g_syn
        localparam logic [N:0] MASK = (N + 1)'(group_mask(R, j));
        assign syndrome[j] = ^(du & MASK);
    end

    assign parity = ^du;

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SECDED decoder with valid/ready flow control.
// Define HAMMING_ERR_CNT_EN to add saturating corrected/uncorrectable counters.
module hamming_secded_pipe
    import hamming_pkg::*;
#(
    parameter int R     = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [calc_n(R):0]    du,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [calc_n(R):0]    dc,
    output logic [calc_k(R)-1:0]  data,
    output logic                  no_error,
    output logic                  corrected,
    output logic                  uncorrectable,
`ifdef HAMMING_ERR_CNT_EN
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt_corr,
    output logic [CNT_W-1:0]      cnt_unc,
`endif
    output logic [R-1:0]          err_pos
);

    localparam int N = calc_n(R);
    localparam int K = calc_k(R);

    logic         adv;
    logic         s1_valid;
    logic [N:0]   s1_du;
    logic [R-1:0] syndrome;
    logic         parity;
    status_e      status_next;
    status_e      status;
    logic [N:0]   dc_next;
    logic [K-1:0] data_next;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the two stages shift as one.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_du    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_du    <= du;
        end
    end

    hamming_syndrome #(.R(R)) u_syndrome (
        .du       (s1_du),
        .syndrome (syndrome),
        .parity   (parity)
    );

    // NOTE: defaults first so no path through this block leaves a variable
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        status_next = ST_NONE;
        dc_next     = s1_du;
        if (s1_valid) begin
            if (parity) begin
                // Syndrome 0 with odd parity lands on bit 0, the parity bit itself.
                status_next = ST_CORR;
                dc_next     = s1_du ^ ((N + 1)'(1) << syndrome);
            end else if (syndrome != '0) begin
                status_next = ST_UNC;
            end else begin
                status_next = ST_OK;
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_data
        localparam int DPOS = data_pos(R, i);
        assign data_next[i] = dc_next[DPOS];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            status    <= ST_NONE;
            dc        <= '0;
            data      <= '0;
            err_pos   <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            status    <= status_next;
            dc        <= dc_next;
            data      <= data_next;
            err_pos   <= syndrome;
        end
    end

    assign no_error      = (status == ST_OK);
    assign corrected     = (status == ST_CORR);
    assign uncorrectable = (status == ST_UNC);

`ifdef HAMMING_ERR_CNT_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset || cnt_clr) begin
            cnt_corr <= '0;
            cnt_unc  <= '0;
        end else if (xfer) begin
            if (corrected && (cnt_corr != '1))     cnt_corr <= cnt_corr + 1'b1;
            if (uncorrectable && (cnt_unc != '1))  cnt_unc  <= cnt_unc + 1'b1;
        end
    end
`endif

endmodule
